// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM states, constants and helpers for the arithmetic unit.
package arith_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    localparam logic [31:0] DIV_ZERO_QUOT = '1;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/div_sub_stage.sv
// div_sub_stage: ripple subtractor a - b as a + ~b + 1 over full-adder cells.
module div_sub_stage #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           no_borrow
);
    logic [WIDTH+1:0] c;
    assign c[0] = 1'b1;
    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        assign diff[i]  = a[i] ^ ~b[i] ^ c[i];
        assign c[i+1]   = (a[i] & ~b[i]) | (c[i] & (a[i] ^ ~b[i]));
    end
    assign no_borrow = c[WIDTH+1];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per clock,
// start/done handshake with divide-by-zero flag.
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d, s, diff;
    logic [WIDTH-1:0] q_q, q_d, dvs_q, dvs_d, quot_q, quot_d, rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d, nb;
    logic             r_top_unused;

    // R is always below the divisor after an iteration, so its top bit never feeds back
    assign r_top_unused = r_q[WIDTH];
    assign s = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    div_sub_stage #(.WIDTH(WIDTH)) u_sub (
        .a(s),
        .b({1'b0, dvs_q}),
        .diff(diff),
        .no_borrow(nb)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (start) begin
                dvs_d   = divisor;
                q_d     = dividend;
                r_d     = '0;
                cnt_d   = '0;
                dbz_d   = divisor == '0;
                state_d = divisor == '0 ? DONE : CALC;
                if (divisor == '0) begin
                    quot_d = DIV_ZERO_QUOT[WIDTH-1:0];
                    rem_d  = dividend;
                end
            end
            CALC: begin
                r_d   = nb ? diff : s;
                q_d   = {q_q[WIDTH-2:0], nb};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    quot_d  = q_d;
                    rem_d   = r_d[WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = state_q != IDLE;
    assign done        = state_q == DONE;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and exhaustive checks of seq_divider against a cycle model.
module tb_seq_divider;
    localparam int W = 4;

    logic         clk, rst_n, start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int total = 0;
    int bad   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: result is plain / and %, ready WIDTH cycles after acceptance
    logic         m_busy, m_done, m_dbz;
    logic [W-1:0] m_q, m_r, p_q, p_r;
    int           m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_dbz = 0; m_q = 0; m_r = 0; m_left = 0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1; m_q = p_q; m_r = p_r;
            end
        end else if (start) begin
            m_busy = 1;
            m_dbz  = 0;
            if (divisor == 0) begin
                m_done = 1; m_dbz = 1; m_q = '1; m_r = dividend;
            end else begin
                m_left = W; p_q = dividend / divisor; p_r = dividend % divisor;
            end
        end
    end

    always @(negedge clk) begin
        check("m_busy", busy, m_busy);
        check("m_done", done, m_done);
        check("m_quot", quotient, m_q);
        check("m_rem", remainder, m_r);
        check("m_dbz", div_by_zero, m_dbz);
    end

    task automatic wait_done(input int elat);
        int n;
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, elat);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input int elat);
        @(negedge clk);
        start = 1; dividend = a; divisor = b;
        @(negedge clk);
        start = 0;
        check("busy_acc", busy, 1);
        wait_done(elat);
        check("quot", quotient, eq);
        check("rem", remainder, er);
        check("dbz", div_by_zero, edbz);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
    endtask

    initial begin
        rst_n = 0; start = 0; dividend = 0; divisor = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quot", quotient, 0);
        check("rst_rem", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst_n = 1;

        do_op(13, 3, 4, 1, 0, 5);
        do_op(15, 1, 15, 0, 0, 5);
        do_op(2, 7, 0, 2, 0, 5);
        do_op(15, 15, 1, 0, 0, 5);
        do_op(0, 5, 0, 0, 0, 5);
        do_op(9, 0, 15, 9, 1, 1);
        do_op(6, 4, 1, 2, 0, 5);

        // start held through CALC/DONE with operands changed after acceptance
        @(negedge clk);
        start = 1; dividend = 13; divisor = 3;
        @(negedge clk);
        dividend = 7; divisor = 2;
        check("held_busy", busy, 1);
        wait_done(5);
        check("held_quot", quotient, 4);
        check("held_rem", remainder, 1);
        @(negedge clk);
        check("held_idle", busy, 0);
        @(negedge clk);
        check("held_reacc", busy, 1);
        start = 0;
        wait_done(5);
        check("held2_quot", quotient, 3);
        check("held2_rem", remainder, 1);
        @(negedge clk);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        start = 1; dividend = 13; divisor = 3;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        #3 rst_n = 0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_quot", quotient, 0);
        check("arst_rem", remainder, 0);
        check("arst_dbz", div_by_zero, 0);
        @(negedge clk);
        check("arst_hold_done", done, 0);
        rst_n = 1;
        do_op(12, 5, 2, 2, 0, 5);

        for (int a = 0; a < 16; a++)
            for (int b = 1; b < 16; b++)
                do_op(W'(a), W'(b), W'(a / b), W'(a % b), 0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
